// File: rtl/ren_pipe_ctrl.sv
// Flow-control wrapper for a fixed-latency enable-gated pipeline: valid shadow chain,
// credit-based admission and a show-ahead output FIFO so no pipeline result is ever lost.
module ren_pipe_ctrl #(
    parameter int unsigned P_WIDTH      = 8,
    parameter int unsigned P_LATENCY    = 8,
    parameter int unsigned P_FIFO_DEPTH = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    output logic               o_ready,
    output logic               o_en,
    input  logic [P_WIDTH-1:0] i_pipe_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [P_WIDTH-1:0] o_data
);

    localparam int unsigned CW = $clog2(P_FIFO_DEPTH + P_LATENCY + 1);
    localparam int unsigned PW = (P_FIFO_DEPTH > 1) ? $clog2(P_FIFO_DEPTH) : 1;

    logic [P_LATENCY-1:0] vld;
    logic [CW-1:0]        inflight;
    logic [CW-1:0]        count;
    logic [CW-1:0]        credit;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [P_WIDTH-1:0]   mem [P_FIFO_DEPTH];
    logic                 accept;
    logic                 push;
    logic                 pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(P_FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Every slot is owned either by a buffered result or by an item still in flight.
    assign credit  = CW'(P_FIFO_DEPTH) - count - inflight;
    assign o_ready = (credit != '0) & ~rst;
    assign accept  = i_valid & o_ready;
    assign o_en    = (accept | (inflight != '0)) & ~rst;
    assign push    = vld[P_LATENCY-1];
    assign o_valid = (count != '0) & ~rst;
    assign pop     = o_valid & i_ready;
    assign o_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
        end else if (o_en) begin
            vld[0] <= accept;
            for (int k = 1; k < P_LATENCY; k++) begin
                vld[k] <= vld[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            case ({accept, push})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= i_pipe_data;
        end
    end

endmodule

// File: tb/tb_ren_pipe_ctrl.sv
// Bench for ren_pipe_ctrl: two configurations, each behind a behavioural delay line,
// checked cycle by cycle against a queue-based item model.
module tb_ren_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_valid;
    logic       i_ready;
    logic [7:0] din;

    logic       a_ready, a_en, a_valid;
    logic [7:0] a_data;
    logic [7:0] a_pipe [8];
    logic       b_ready, b_en, b_valid;
    logic [7:0] b_data;
    logic [7:0] b_pipe;

    always #5 clk = ~clk;

    ren_pipe_ctrl #(.P_WIDTH(8), .P_LATENCY(8), .P_FIFO_DEPTH(10)) dut_a (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(a_ready), .o_en(a_en),
        .i_pipe_data(a_pipe[7]), .o_valid(a_valid), .i_ready(i_ready), .o_data(a_data)
    );

    ren_pipe_ctrl #(.P_WIDTH(8), .P_LATENCY(1), .P_FIFO_DEPTH(3)) dut_b (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(b_ready), .o_en(b_en),
        .i_pipe_data(b_pipe), .o_valid(b_valid), .i_ready(i_ready), .o_data(b_data)
    );

    // Enable-gated delay lines standing in for the real datapath.
    always @(posedge clk) begin
        if (a_en) begin
            a_pipe[0] <= din;
            for (int k = 1; k < 8; k++) a_pipe[k] <= a_pipe[k-1];
        end
        if (b_en) b_pipe <= din;
    end

    int errors = 0;
    int checks = 0;
    bit sel;
    int lat;
    int depth;
    int fl_data[$];
    int fl_stage[$];
    int fifo[$];
    bit obs_acc;
    int idx;
    int acc_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, compare against the item model, then advance the model.
    task automatic step(input bit r, input bit v, input logic [7:0] d, input bit rdy);
        bit exp_ready, exp_en, exp_valid, acc;
        logic o_r, o_e, o_v;
        logic [7:0] o_d;
        rst = r; i_valid = v; din = d; i_ready = rdy;
        #2;
        exp_ready = !r && (depth - fifo.size() - fl_data.size()) != 0;
        acc       = v && exp_ready;
        exp_en    = !r && (acc || fl_data.size() != 0);
        exp_valid = !r && fifo.size() != 0;
        o_r = sel ? b_ready : a_ready;
        o_e = sel ? b_en    : a_en;
        o_v = sel ? b_valid : a_valid;
        o_d = sel ? b_data  : a_data;
        chk("o_ready", {31'd0, o_r}, {31'd0, exp_ready});
        chk("o_en",    {31'd0, o_e}, {31'd0, exp_en});
        chk("o_valid", {31'd0, o_v}, {31'd0, exp_valid});
        if (exp_valid) chk("o_data", {24'd0, o_d}, fifo[0]);
        obs_acc = (o_r === 1'b1) && v;
        @(posedge clk);
        if (r) begin
            fl_data.delete(); fl_stage.delete(); fifo.delete();
        end else begin
            if (exp_valid && rdy) void'(fifo.pop_front());
            if (exp_en) begin
                if (fl_stage.size() != 0 && fl_stage[0] == lat) begin
                    fifo.push_back(fl_data.pop_front());
                    void'(fl_stage.pop_front());
                end
                foreach (fl_stage[i]) fl_stage[i]++;
                if (acc) begin
                    fl_data.push_back(int'(d));
                    fl_stage.push_back(1);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, rdy);
    endtask

    task automatic random_run(input int n);
        bit hold;
        for (int i = 0; i < n; i++) begin
            if (i % 40 == 0) hold = ($urandom_range(0, 2) == 0);
            step($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0,
                 8'($urandom), hold ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0));
        end
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; din = 8'h00;
        sel = 1'b0; lat = 8; depth = 10;
        @(negedge clk);

        // Reset with upstream pushing, then first accept on release.
        step(1'b1, 1'b1, 8'h11, 1'b1);
        step(1'b1, 1'b1, 8'h11, 1'b1);
        step(1'b0, 1'b1, 8'h11, 1'b1);
        idle(12, 1'b1);

        // Single item.
        step(1'b0, 1'b1, 8'hA5, 1'b1);
        idle(12, 1'b1);

        // Back-to-back stream.
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'(i), 1'b1);
        idle(12, 1'b1);

        // Backpressure: exactly ten credits, then release.
        idx = 0; acc_cnt = 0;
        for (int c = 0; c < 25; c++) begin
            step(1'b0, idx < 15, 8'(idx), 1'b0);
            if (obs_acc) begin idx++; acc_cnt++; end
        end
        chk("bp_accepted", acc_cnt, 10);
        for (int c = 0; c < 60 && idx < 15; c++) begin
            step(1'b0, 1'b1, 8'(idx), 1'b1);
            if (obs_acc) idx++;
        end
        chk("bp_all_accepted", idx, 15);
        idle(14, 1'b1);

        // Reset with five in flight and three buffered.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
        idle(3, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        idle(20, 1'b1);

        random_run(500);
        idle(14, 1'b1);

        // Short-latency, shallow configuration.
        sel = 1'b1; lat = 1; depth = 3;
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        idx = 0;
        for (int c = 0; c < 60 && idx < 8; c++) begin
            step(1'b0, 1'b1, 8'(8'h80 + idx), (c % 2) == 0);
            if (obs_acc) idx++;
        end
        chk("b_all_accepted", idx, 8);
        idle(6, 1'b1);
        random_run(400);
        idle(6, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
